div_unit: RTL and testbench

- Iterative multi-cycle divide/remainder unit implementing RV32M DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the data path. It takes the same srcA/srcB operands and returns a 32-bit result.
- The decoder/control raises start and stalls the pipeline while busy is high.
- Radix-2 restoring algorithm, one quotient bit per clock, fixed latency.

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_unit.sv | 165 ++++++++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared encodings for the iterative divide/remainder unit.
// The ALU decoder uses the same divOp encodings when it generates divOp.
package div_unit_pkg;

  localparam logic [1:0] DIVOP_DIV  = 2'b00;
  localparam logic [1:0] DIVOP_DIVU = 2'b01;
  localparam logic [1:0] DIVOP_REM  = 2'b10;
  localparam logic [1:0] DIVOP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // One quotient bit is produced per CALC edge.
  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed latency: start edge, 32 iteration edges, one sign-fix edge.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, only sampled while idle
//   flush     synchronous abort back to idle (no done)
//   divOp     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   srcA/srcB dividend / divisor, sampled on the accepting edge only
//   busy      operation in flight
//   done      one-cycle pulse, res valid in the same cycle
//   res       quotient or remainder, held until the next done
//   divByZero registered alongside res, set when the divisor was 0
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       divOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             divByZero
);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIVOP_DIV) || (op == DIVOP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIVOP_REM) || (op == DIVOP_REMU);
  endfunction

  // Control state (asynchronously reset)
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;

  // Datapath state (no reset; only meaningful while busy)
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             zero_b_q, zero_b_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    res_d     = res_q;
    dbz_d     = dbz_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    zero_b_d  = zero_b_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;

    // 33-bit partial remainder after shifting in the next dividend bit.
    // When it is >= divisor the difference always fits in WIDTH bits.
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - divisor_q;

    // Divide by zero leaves an all-ones quotient which must not be negated.
    quot_fix = ((sign_a_q ^ sign_b_q) && !zero_b_q) ? negate(quot_q) : quot_q;
    rem_fix  = sign_a_q ? negate(rem_q) : rem_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d      = divOp;
            sign_a_d  = op_is_signed(divOp) & srcA[WIDTH-1];
            sign_b_d  = op_is_signed(divOp) & srcB[WIDTH-1];
            zero_b_d  = (srcB == '0);
            quot_d    = op_is_signed(divOp) ? magnitude(srcA) : srcA;
            divisor_d = op_is_signed(divOp) ? magnitude(srcB) : srcB;
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = ST_CALC;
          end
        end
        ST_CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (shifted >= {1'b0, divisor_q}) begin
            rem_d  = diff;
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = shifted[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          res_d   = op_is_rem(op_q) ? rem_fix : quot_fix;
          dbz_d   = zero_b_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q      <= op_d;
    sign_a_q  <= sign_a_d;
    sign_b_q  <= sign_b_d;
    zero_b_q  <= zero_b_d;
    divisor_q <= divisor_d;
    rem_q     <= rem_d;
    quot_q    <= quot_d;
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign res       = res_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Directed RV32M cases,
// protocol cases (start while busy, flush, async reset) and random ops
// compared against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  divOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        divByZero;

  int checks;
  int errors;
  logic [31:0] last_res;
  logic        last_dbz;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .divOp(divOp),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .res(res),
    .divByZero(divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Issue one operation, optionally re-pulse start while busy, and check
  // latency, busy length, result and divByZero.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int repulse_at);
    int cyc;
    int busy_cnt;
    int extra;
    @(negedge clk);
    chk({tag, "_done_low_before"}, 32'(done), 32'd0);
    start = 1'b1; divOp = op; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; divOp = 2'($urandom); srcA = $urandom; srcB = $urandom;
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      start = (cyc == repulse_at);
      if (start) begin
        srcA = 32'd5; srcB = 32'd1; divOp = 2'b01;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, 34);
    chk({tag, "_busy_cycles"}, busy_cnt, 33);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_dbz"}, 32'(divByZero), 32'(b == 32'd0));
    last_res = exp;
    last_dbz = (b == 32'd0);
    if (repulse_at > 0) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, "_single_done"}, extra, 0);
      chk({tag, "_res_held"}, res, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[10];

  initial begin
    int dones;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] special[4];

    checks = 0; errors = 0;
    last_res = 32'd0; last_dbz = 1'b0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; divOp = 2'b00;
    srcA = 32'd0; srcB = 32'd0;

    dir[0] = '{2'b01, 32'd1025, 32'd1000, 32'h0000_0001};
    dir[1] = '{2'b11, 32'd1025, 32'd1000, 32'h0000_0019};
    dir[2] = '{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    dir[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    dir[4] = '{2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    dir[5] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001};
    dir[6] = '{2'b00, 32'd513, 32'd0, 32'hFFFF_FFFF};
    dir[7] = '{2'b10, 32'd513, 32'd0, 32'h0000_0201};
    dir[8] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    dir[9] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_dbz", 32'(divByZero), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_res", res, 32'd0);
    end

    // Directed cases, back to back
    foreach (dir[i]) begin
      chk("model_vs_table", ref_res(dir[i].op, dir[i].a, dir[i].b), dir[i].exp);
      do_op("dir", dir[i].op, dir[i].a, dir[i].b, dir[i].exp, 0);
    end

    // start while busy is ignored
    do_op("repulse", 2'b01, 32'd1000, 32'd7, 32'd142, 10);

    // flush mid-operation: no done, res/divByZero untouched, then a normal op
    @(negedge clk);
    start = 1'b1; divOp = 2'b00; srcA = 32'd99; srcB = 32'd0;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (done) dones++;
      flush = (cyc == 15);
      @(negedge clk);
    end
    flush = 1'b0;
    chk("flush_no_done", dones, 0);
    chk("flush_res_kept", res, last_res);
    chk("flush_dbz_kept", 32'(divByZero), 32'(last_dbz));
    chk("flush_idle", 32'(busy), 32'd0);
    do_op("after_flush", 2'b01, 32'd1000, 32'd7, 32'd142, 0);

    // Async reset mid-CALC
    @(negedge clk);
    start = 1'b1; divOp = 2'b11; srcA = 32'd12345; srcB = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_res", res, 32'd0);
    chk("async_dbz", 32'(divByZero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0; last_dbz = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("post_reset_no_done", dones, 0);
    chk("post_reset_res", res, 32'd0);

    // Random operations, with edge-value operands mixed in
    special[0] = 32'd0;
    special[1] = 32'd1;
    special[2] = 32'hFFFF_FFFF;
    special[3] = 32'h8000_0000;
    for (int n = 0; n < 150; n++) begin
      rop = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = special[$urandom_range(0, 3)];
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_op("rand", rop, ra, rb, ref_res(rop, ra, rb), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
